// File: rtl/video_system_onchip_memory_pipelined_if.sv
// Avalon-MM slave bundle for the pipelined on-chip memory.
// Carries address/data, request strobes, clock-enable hold and flow-control returns.
interface video_system_onchip_memory_pipelined_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 12
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] address;
    logic [BE_WIDTH-1:0]   byteenable;
    logic                  chipselect;
    logic                  read;
    logic                  write;
    logic [DATA_WIDTH-1:0] writedata;
    logic                  clken;
    logic                  reset_req;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  readdatavalid;
    logic                  waitrequest;

    modport master (
        output address, byteenable, chipselect, read, write, writedata, clken, reset_req,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, byteenable, chipselect, read, write, writedata, clken, reset_req,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/video_system_onchip_memory_pipelined.sv
// Single-port on-chip RAM on Avalon-MM with byte enables, 1- or 2-cycle read latency,
// waitrequest flow control and an optional post-reset clear sweep.
module video_system_onchip_memory_pipelined #(
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           ADDR_WIDTH     = 12,
    parameter int unsigned           READ_LATENCY   = 1,
    parameter int unsigned           CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic clk,
    input  logic reset,
    video_system_onchip_memory_pipelined_if.slave avs
);
    localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned NSTG     = READ_LATENCY + 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;
    logic                  w_en;
    logic                  w_clear_we;
    logic                  w_waitreq;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic [BE_WIDTH-1:0]   w_mem_be;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_q;
    logic [DATA_WIDTH-1:0] r_pipe [READ_LATENCY];
    logic [NSTG-1:0]       r_vld;

    // Reset is folded into the enable so nothing is accepted or cleared while it is held.
    assign w_en      = avs.clken & ~avs.reset_req & ~reset;
    assign w_waitreq = (r_state == ST_CLEAR) | ~w_en;
    assign w_wr_acc  = avs.chipselect & avs.write & ~w_waitreq;
    assign w_rd_acc  = avs.chipselect & avs.read & ~avs.write & ~w_waitreq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RESET_STATE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clear_we  = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                if (w_en) begin
                    w_clear_we = 1'b1;
                    w_cnt_nxt  = r_cnt + 1'b1;
                    if (r_cnt == '1) begin
                        w_state_nxt = ST_READY;
                    end
                end
            end
            ST_READY: begin
                w_state_nxt = ST_READY;
            end
            default: begin
                w_state_nxt = RESET_STATE;
            end
        endcase
    end

    // Single write port shared between the clear sweep and bus writes.
    assign w_mem_we    = w_clear_we | w_wr_acc;
    assign w_mem_addr  = w_clear_we ? r_cnt : avs.address;
    assign w_mem_wdata = w_clear_we ? CLEAR_VALUE : avs.writedata;
    assign w_mem_be    = w_clear_we ? {BE_WIDTH{1'b1}} : avs.byteenable;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int unsigned b = 0; b < BE_WIDTH; b++) begin
                if (w_mem_be[b]) begin
                    r_mem[w_mem_addr][b*8 +: 8] <= w_mem_wdata[b*8 +: 8];
                end
            end
        end
        if (w_rd_acc) begin
            r_rd_q <= r_mem[avs.address];
        end
    end

    // Valid bits and data stages advance together and freeze while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else if (w_en) begin
            r_vld <= {r_vld[NSTG-2:0], w_rd_acc};
            if (r_vld[0]) begin
                r_pipe[0] <= r_rd_q;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                if (r_vld[i]) begin
                    r_pipe[i] <= r_pipe[i-1];
                end
            end
        end
    end

    assign avs.readdata      = r_pipe[READ_LATENCY-1];
    assign avs.readdatavalid = r_vld[READ_LATENCY];
    assign avs.waitrequest   = w_waitreq;
endmodule

// File: tb/tb_video_system_onchip_memory_pipelined.sv
// Bench for the pipelined on-chip memory: directed scenarios then random traffic,
// checked against a word-array model with enabled-edge-indexed read results.
module tb_video_system_onchip_memory_pipelined;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 4;
    localparam int          LAT   = 2;
    localparam int          DEPTH = 16;
    localparam logic [31:0] CV    = 32'hA5A5A5A5;

    logic clk;
    logic reset;

    video_system_onchip_memory_pipelined_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    video_system_onchip_memory_pipelined #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .READ_LATENCY  (LAT),
        .CLEAR_ON_RESET(1),
        .CLEAR_VALUE   (CV)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .avs  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          idx;
        logic [31:0] data;
    } rd_t;

    logic [31:0] mem_m [DEPTH];
    rd_t         rq [$];
    logic [31:0] last_data;
    int          e_cnt, clear_cnt;
    int          checks, passes;
    int          cyc, vld_count, last_vld_cyc, wait_count;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    // One clock: drive at negedge, check waitrequest, advance model at posedge, check outputs.
    task automatic step(input logic cs, input logic rd, input logic wr, input logic [3:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        input logic ce, input logic rr, input logic rst);
        logic en;
        logic exp_wait;
        logic exp_v;
        @(negedge clk);
        bus.chipselect = cs;
        bus.read       = rd;
        bus.write      = wr;
        bus.address    = a;
        bus.byteenable = be;
        bus.writedata  = wd;
        bus.clken      = ce;
        bus.reset_req  = rr;
        reset          = rst;
        en = ce & ~rr;
        if (rst) begin
            clear_cnt = 0;
            rq.delete();
            last_data = '0;
        end
        #1;
        exp_wait = rst | (clear_cnt < DEPTH) | ~en;
        chk("waitrequest", 32'(bus.waitrequest), 32'(exp_wait));
        if (bus.waitrequest && ce && !rr && !rst) wait_count++;
        @(posedge clk);
        cyc++;
        if (!rst && en) begin
            e_cnt++;
            if (clear_cnt < DEPTH) begin
                clear_cnt++;
                if (clear_cnt == DEPTH) foreach (mem_m[i]) mem_m[i] = CV;
            end else if (cs && wr) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mem_m[a][b*8 +: 8] = wd[b*8 +: 8];
            end else if (cs && rd) begin
                rq.push_back('{e_cnt, mem_m[a]});
            end
        end
        #1;
        while (rq.size() > 0 && rq[0].idx + LAT < e_cnt) void'(rq.pop_front());
        exp_v = (rq.size() > 0) && (rq[0].idx + LAT == e_cnt);
        if (exp_v) last_data = rq[0].data;
        chk("readdatavalid", 32'(bus.readdatavalid), 32'(exp_v));
        chk("readdata", bus.readdata, last_data);
        if (bus.readdatavalid) begin
            vld_count++;
            last_vld_cyc = cyc;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_wr(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
        step(1'b1, 1'b0, 1'b1, a, be, d, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_rd(input logic [3:0] a);
        step(1'b1, 1'b1, 1'b0, a, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic stall(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int c0, v0;
        checks = 0; passes = 0; cyc = 0; vld_count = 0; last_vld_cyc = 0; wait_count = 0;
        e_cnt = 0; clear_cnt = 0; last_data = '0;
        reset = 1'b1;
        bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0; bus.address = '0;
        bus.byteenable = '0; bus.writedata = '0; bus.clken = 1'b1; bus.reset_req = 1'b0;

        // Reset state and clear sweep length
        repeat (2) step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        wait_count = 0;
        idle(20);
        chk("clear_len", 32'(wait_count), 32'd16);
        do_rd(4'd9);
        idle(2);
        chk("clear_fill", bus.readdata, 32'hA5A5A5A5);

        // Byte-masked write
        do_wr(4'd3, 4'b1111, 32'h11223344);
        do_wr(4'd3, 4'b0101, 32'hFFFFFFFF);
        do_rd(4'd3);
        idle(2);
        chk("byte_mask", bus.readdata, 32'h11FF33FF);

        // Streaming reads
        do_wr(4'd0, 4'hF, 32'd10);
        do_wr(4'd1, 4'hF, 32'd20);
        do_wr(4'd2, 4'hF, 32'd30);
        do_rd(4'd0);
        do_rd(4'd1);
        do_rd(4'd2);
        chk("stream_0", bus.readdata, 32'd10);
        idle(1);
        chk("stream_1", bus.readdata, 32'd20);
        idle(1);
        chk("stream_2", bus.readdata, 32'd30);
        idle(1);
        chk("stream_hold", bus.readdata, 32'd30);

        // Stall mid-pipeline
        do_rd(4'd5);
        c0 = cyc;
        v0 = vld_count;
        stall(3);
        idle(3);
        chk("stall_latency", 32'(last_vld_cyc - c0), 32'(LAT + 3));
        chk("stall_once", 32'(vld_count - v0), 32'd1);

        // Valid high when the stall begins, then a one-cycle reset_req pulse
        do_rd(4'd1);
        idle(2);
        stall(2);
        idle(2);
        do_rd(4'd2);
        step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        idle(3);
        do_rd(4'd3);
        idle(2);
        chk("reset_req_no_clear", bus.readdata, 32'h11FF33FF);

        // Reset mid-sweep restarts the full sweep
        step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        idle(7);
        step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        wait_count = 0;
        idle(20);
        chk("resweep_len", 32'(wait_count), 32'd16);

        // Read/write collision is a write only
        v0 = vld_count;
        step(1'b1, 1'b1, 1'b1, 4'd4, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
        idle(3);
        chk("collision_novalid", 32'(vld_count - v0), 32'd0);
        do_rd(4'd4);
        idle(2);
        chk("collision_wrote", bus.readdata, 32'hDEADBEEF);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 4'($urandom),
                 4'($urandom), $urandom, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 249) == 0);
        end
        idle(5);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
